// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its execution unit.
// Also carries exec-unit latency constants and the exec FSM state encoding.
package instr_register_pkg;

    localparam int OPERAND_WIDTH = 32;
    localparam int RESULT_WIDTH  = 64;

    localparam int DIV_LATENCY = OPERAND_WIDTH + 2;
    localparam int POW_LATENCY = OPERAND_WIDTH + 1;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef logic signed [OPERAND_WIDTH-1:0] operand_t;
    typedef logic signed [RESULT_WIDTH-1:0]  result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } exec_state_t;

    function automatic logic is_multicycle(input opcode_t opc);
        return (opc == DIV) || (opc == MOD) || (opc == POW);
    endfunction

endpackage

// File: rtl/instr_exec_divider.sv
// Iterative signed restoring divider: start edge captures magnitudes, OP_WIDTH
// iteration edges follow, done is asserted combinationally on the next cycle with sign-fixed outputs.
module instr_exec_divider
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = OPERAND_WIDTH,
    parameter int RES_WIDTH = RESULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [OP_WIDTH-1:0]         dividend,
    input  logic [OP_WIDTH-1:0]         divisor,
    output logic                        done,
    output logic signed [RES_WIDTH-1:0] quotient,
    output logic signed [RES_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(OP_WIDTH + 1);

    logic                active;
    logic [CNT_W-1:0]    cnt;
    logic [OP_WIDTH-1:0] quo;
    logic [OP_WIDTH-1:0] rem;
    logic [OP_WIDTH-1:0] dvs;
    logic                neg_q;
    logic                neg_r;
    logic [OP_WIDTH:0]   shifted;
    logic [OP_WIDTH:0]   diff;
    logic signed [RES_WIDTH-1:0] q_ext;
    logic signed [RES_WIDTH-1:0] r_ext;

    always_comb begin
        shifted = {rem, quo[OP_WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (start) begin
            // Most-negative dividend maps to 2^(OP_WIDTH-1), which fits unsigned.
            quo    <= dividend[OP_WIDTH-1] ? -dividend : dividend;
            dvs    <= divisor[OP_WIDTH-1]  ? -divisor  : divisor;
            rem    <= '0;
            neg_q  <= dividend[OP_WIDTH-1] ^ divisor[OP_WIDTH-1];
            neg_r  <= dividend[OP_WIDTH-1];
            cnt    <= CNT_W'(OP_WIDTH);
            active <= 1'b1;
        end else if (active) begin
            if (cnt != '0) begin
                if (!diff[OP_WIDTH]) begin
                    rem <= diff[OP_WIDTH-1:0];
                    quo <= {quo[OP_WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[OP_WIDTH-1:0];
                    quo <= {quo[OP_WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    always_comb begin
        q_ext     = {{(RES_WIDTH-OP_WIDTH){1'b0}}, quo};
        r_ext     = {{(RES_WIDTH-OP_WIDTH){1'b0}}, rem};
        quotient  = neg_q ? -q_ext : q_ext;
        remainder = neg_r ? -r_ext : r_ext;
        done      = active && (cnt == '0);
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution unit for instruction_t words: 1-cycle ALU ops, iterative DIV/MOD/POW.
// Results are held in DONE until out_ready; no new instruction is taken outside IDLE.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = OPERAND_WIDTH,
    parameter int RES_WIDTH = RESULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  instruction_t                in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [RES_WIDTH-1:0] out_result,
    output opcode_t                     out_opc,
    output logic                        out_exc,
    output logic                        busy
);

    localparam int CNT_W = $clog2(DIV_LATENCY);

    exec_state_t                 state;
    logic [CNT_W-1:0]            cnt;
    opcode_t                     cur_opc;
    logic                        div_zero;
    logic signed [RES_WIDTH-1:0] pow_a;
    logic [OP_WIDTH-1:0]         pow_b;
    logic signed [RES_WIDTH-1:0] pow_acc;
    logic                        pow_force_zero;

    logic                        accept;
    logic                        div_start;
    logic                        div_done;
    logic signed [RES_WIDTH-1:0] div_quo;
    logic signed [RES_WIDTH-1:0] div_rem;
    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;
    logic signed [RES_WIDTH-1:0] alu_res;
    logic                        alu_exc;
    logic signed [RES_WIDTH-1:0] pow_sq;
    logic signed [RES_WIDTH-1:0] pow_next;
    logic                        unused_rezultat;

    assign unused_rezultat = ^in_instr.rezultat;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && ((in_instr.opc == DIV) || (in_instr.opc == MOD));
    assign busy      = (state != IDLE);

    always_comb begin
        a_ext   = {{(RES_WIDTH-OP_WIDTH){in_instr.op_a[OP_WIDTH-1]}}, in_instr.op_a};
        b_ext   = {{(RES_WIDTH-OP_WIDTH){in_instr.op_b[OP_WIDTH-1]}}, in_instr.op_b};
        alu_res = '0;
        alu_exc = 1'b0;
        case (in_instr.opc)
            ZERO:          alu_res = '0;
            PASSA:         alu_res = a_ext;
            PASSB:         alu_res = b_ext;
            ADD:           alu_res = a_ext + b_ext;
            SUB:           alu_res = a_ext - b_ext;
            MULT:          alu_res = a_ext * b_ext;
            DIV, MOD, POW: alu_res = '0;
            default:       alu_exc = 1'b1;
        endcase
    end

    // Square-and-multiply, exponent consumed MSB first via a left shift.
    always_comb begin
        pow_sq   = pow_acc * pow_acc;
        pow_next = pow_b[OP_WIDTH-1] ? pow_sq * pow_a : pow_sq;
    end

    instr_exec_divider #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (in_instr.op_a),
        .divisor   (in_instr.op_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_opc        <= ZERO;
            out_exc        <= 1'b0;
            cnt            <= '0;
            cur_opc        <= ZERO;
            div_zero       <= 1'b0;
            pow_a          <= '0;
            pow_b          <= '0;
            pow_acc        <= '0;
            pow_force_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_opc        <= in_instr.opc;
                        div_zero       <= (in_instr.op_b == '0);
                        pow_a          <= a_ext;
                        pow_b          <= in_instr.op_b;
                        pow_acc        <= RES_WIDTH'(1);
                        pow_force_zero <= (in_instr.op_a == '0) || in_instr.op_b[OP_WIDTH-1];
                        in_ready       <= 1'b0;
                        if (is_multicycle(in_instr.opc)) begin
                            state <= CALC;
                            // POW counts OP_WIDTH steps down to zero; DIV/MOD just track progress.
                            cnt   <= (in_instr.opc == POW) ? CNT_W'(POW_LATENCY - 2)
                                                           : CNT_W'(DIV_LATENCY - 1);
                        end else begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= alu_res;
                            out_opc    <= in_instr.opc;
                            out_exc    <= alu_exc;
                        end
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cur_opc == POW) begin
                        pow_acc <= pow_next;
                        pow_b   <= pow_b << 1;
                        if (cnt == '0) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= pow_force_zero ? '0 : pow_next;
                            out_opc    <= cur_opc;
                            out_exc    <= 1'b0;
                        end
                    end else if (div_done) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= div_zero ? '0 : ((cur_opc == MOD) ? div_rem : div_quo);
                        out_opc    <= cur_opc;
                        out_exc    <= div_zero;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execution-side consumer of instruction_t words read out of the instruction register stack.
- Accepts one instruction ({opc, op_a, op_b}) per valid/ready handshake and computes the result that the register bench checks as rezultat.
- Returns the result through a second valid/ready handshake.
- ZERO/PASSA/PASSB/ADD/SUB/MULT complete in one cycle; DIV/MOD use an iterative restoring divider and POW uses iterative square-and-multiply.

Parameters:
OP_WIDTH, 32, operand width (matches operand_t, signed)
RES_WIDTH, 64, result width (matches result_t, signed); must be >= 2*OP_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_instr is valid
in_ready  output  1  unit can accept an instruction
in_instr  input  instruction_t  {opc, op_a, op_b, rezultat}; rezultat field ignored
out_valid  output  1  out_result is valid
out_ready  input  1  downstream accepts the result
out_result  output  RES_WIDTH  signed result
out_opc  output  opcode_t  opcode of the instruction that produced out_result
out_exc  output  1  exception: divide/modulo by zero, or illegal opcode
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_opc=ZERO, out_exc=0, busy=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On an accept edge (in_valid & in_ready), latch opc, op_a, op_b.
  - Single-cycle opcode: go to DONE; out_valid=1 on the same edge (latency 1).
  - DIV/MOD/POW: go to CALC.
- CALC: in_ready=0, busy=1, counter decrements each cycle.
  - DIV/MOD: setup edge converts operands to magnitudes; then OP_WIDTH restoring iterations; final edge applies sign fix and enters DONE. Total OP_WIDTH+2 edges from accept to out_valid=1.
  - POW: OP_WIDTH square-and-multiply steps scanning op_b from MSB to LSB; the final step enters DONE. Total OP_WIDTH+1 edges. Intermediates are truncated to RES_WIDTH.
- DONE: out_valid=1; out_result, out_opc and out_exc are stable until the handshake completes.
  - On out_ready: out_valid drops and the unit returns to IDLE.
  - in_ready=0 in DONE. There is no same-cycle re-accept; throughput is at most 1 instruction per 2 cycles.
- Arithmetic (signed; operands sign-extended to RES_WIDTH before the op):
  - ZERO -> 0; PASSA -> op_a; PASSB -> op_b.
  - ADD -> op_a+op_b; SUB -> op_a-op_b; MULT -> full signed product.
  - DIV -> quotient truncated toward zero.
  - MOD -> remainder, sign follows op_a.
  - op_b==0 for DIV/MOD -> result 0, out_exc=1; the unit still uses the full CALC latency.
  - POW: op_a==0 -> 0; op_b<0 -> 0; op_b==0 with op_a!=0 -> 1; otherwise op_a**op_b mod 2^RES_WIDTH.
  - Opcode encoding outside opcode_t -> result 0, out_exc=1, latency 1.
- Boundary cases:
  - in_valid held while busy: the instruction is not consumed and stays pending upstream.
  - out_ready held high continuously: the result is visible for exactly 1 cycle.
  - out_ready low: the unit holds DONE indefinitely.
  - Most-negative op_a with DIV by -1: result is +2^(OP_WIDTH-1), which fits in RES_WIDTH.
  - Reset asserted mid-CALC: the computation is aborted, no out_valid is produced, and the unit is back to IDLE when reset releases.
- in_ready and out_valid are registered outputs, with no combinational path from the inputs.

Decomposition:
- Package instr_register_pkg holds: opcode_t, operand_t, result_t, instruction_t, and the new constants DIV_LATENCY=OP_WIDTH+2 and POW_LATENCY=OP_WIDTH+1.
- The exec-state enum (IDLE/CALC/DONE) is also added to the package so the bench can probe it.
- One sub-module: instr_exec_divider, the iterative signed restoring divider with start/done and quotient/remainder outputs. The POW datapath and the single-cycle ALU stay in the top.

Test Plan:
- Reset, then ADD op_a=-7 op_b=12 with out_ready=1 -> out_valid 1 cycle after accept, out_result=5, out_exc=0.
- DIV op_a=-15 op_b=4 -> out_result=-3 exactly 34 cycles after accept. MOD with the same operands -> -3.
- DIV op_a=9 op_b=0 -> out_result=0, out_exc=1, latency 34. POW op_a=0 op_b=5 -> 0.
- POW op_a=-3 op_b=5 -> -243 after 33 cycles. POW op_a=7 op_b=0 -> 1. POW op_a=2 op_b=-1 -> 0.
- Backpressure: MULT 15*-15 with out_ready=0 for 10 cycles -> out_valid, out_result=-225 and out_opc=MULT stay stable; in_ready=0 throughout.
- Reset pulse 10 cycles into a DIV -> all outputs return to reset values asynchronously; the next PASSB op_b=11 returns 11 with no stale result.
